// File: rtl/outbuf_drain.sv
// ---------------------------------------------------------------------------
// outbuf_drain
//   South-edge output FIFO for one PE-array column. The column emits result
//   words with no backpressure; the first SKIP words after reset/clear are
//   array skew and are thrown away. The remaining words are buffered and
//   handed to the downstream collector over a valid/ready handshake.
//
// Ports
//   clk        in   rising-edge clock
//   rstn       in   asynchronous reset, active low
//   clear      in   synchronous flush (same as reset, memory untouched)
//   in_valid   in   din carries a column result; never stalled
//   din        in   column result word
//   out_valid  out  FIFO non-empty, dout valid
//   out_ready  in   downstream takes dout this cycle
//   dout       out  head word, 0 when out_valid=0
//   count      out  words stored, 0..BUFSIZE
//   full       out  count == BUFSIZE
//   overflow   out  sticky: a word was lost because the FIFO was full
// ---------------------------------------------------------------------------
module outbuf_drain #(
    parameter int WORDLEN = 8,
    parameter int BUFSIZE = 10,   // 2..32
    parameter int SKIP    = 0     // 0..31
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [WORDLEN-1:0] din,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORDLEN-1:0] dout,
    output logic [5:0]         count,
    output logic               full,
    output logic               overflow
);

    typedef enum logic {ST_SKIP, ST_ACTIVE} state_e;

    localparam int          AW        = (BUFSIZE > 1) ? $clog2(BUFSIZE) : 1;
    localparam state_e      RST_STATE = (SKIP > 0) ? ST_SKIP : ST_ACTIVE;
    // Only consulted while skipping, which never happens when SKIP == 0.
    localparam logic [4:0]  SKIP_LAST = (SKIP > 0) ? 5'(SKIP - 1) : 5'd0;
    localparam logic [4:0]  PTR_LAST  = 5'(BUFSIZE - 1);
    localparam logic [5:0]  DEPTH     = 6'(BUFSIZE);

    state_e             state_q, state_d;
    logic [4:0]         skip_q, skip_d;
    logic [4:0]         head_q, head_d;
    logic [4:0]         tail_q, tail_d;
    logic [5:0]         count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               push, pop;

    logic [WORDLEN-1:0] mem [BUFSIZE];

    function automatic logic [4:0] ptr_inc(input logic [4:0] p);
        return (p == PTR_LAST) ? 5'd0 : p + 5'd1;
    endfunction

    // Outputs depend on registered state only.
    assign out_valid = (count_q != 6'd0);
    assign full      = (count_q == DEPTH);
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign dout      = out_valid ? mem[head_q[AW-1:0]] : '0;

    // clear overrides both handshakes in its cycle.
    assign pop  = !clear && out_valid && out_ready;
    assign push = !clear && (state_q == ST_ACTIVE) && in_valid && (!full || pop);

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (clear) begin
            state_d = RST_STATE;
            skip_d  = 5'd0;
            head_d  = 5'd0;
            tail_d  = 5'd0;
            count_d = 6'd0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_SKIP: begin
                    if (in_valid) begin
                        skip_d = skip_q + 5'd1;
                        // The SKIP-th word is still discarded; pushing starts after it.
                        if (skip_q == SKIP_LAST) state_d = ST_ACTIVE;
                    end
                end
                default: begin
                    if (in_valid && full && !pop) ovf_d = 1'b1;
                end
            endcase

            if (push) tail_d = ptr_inc(tail_q);
            if (pop)  head_d = ptr_inc(head_q);
            case ({push, pop})
                2'b10:   count_d = count_q + 6'd1;
                2'b01:   count_d = count_q - 6'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RST_STATE;
            skip_q  <= 5'd0;
            head_q  <= 5'd0;
            tail_q  <= 5'd0;
            count_q <= 6'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is not reset; out_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (push) mem[tail_q[AW-1:0]] <= din;
    end

endmodule

// File: tb/tb_outbuf_drain.sv
module tb_outbuf_drain;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] din = 8'd0;
    logic       out_ready = 1'b0;

    // u0: BUFSIZE=4, SKIP=0   u1: BUFSIZE=10, SKIP=2
    logic       ov0, ov1, fl0, fl1, of0, of1;
    logic [7:0] do0, do1;
    logic [5:0] cn0, cn1;

    outbuf_drain #(.WORDLEN(8), .BUFSIZE(4), .SKIP(0)) u0 (
        .clk(clk), .rstn(rstn), .clear(clear), .in_valid(in_valid), .din(din),
        .out_valid(ov0), .out_ready(out_ready), .dout(do0), .count(cn0),
        .full(fl0), .overflow(of0));

    outbuf_drain #(.WORDLEN(8), .BUFSIZE(10), .SKIP(2)) u1 (
        .clk(clk), .rstn(rstn), .clear(clear), .in_valid(in_valid), .din(din),
        .out_valid(ov1), .out_ready(out_ready), .dout(do1), .count(cn1),
        .full(fl1), .overflow(of1));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a queue per instance ----------------
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int  sk0 = 0, sk1 = 2;     // words still to be discarded
    bit  mo0 = 0, mo1 = 0;     // overflow flags
    bit  pp;

    always @(posedge clk or negedge rstn) begin
        if (!rstn || clear) begin
            q0.delete(); q1.delete();
            sk0 = 0; sk1 = 2; mo0 = 0; mo1 = 0;
        end else begin
            // instance 0
            pp = out_ready && q0.size() != 0;
            if (pp) void'(q0.pop_front());
            if (in_valid) begin
                if (sk0 > 0) sk0--;
                else if (q0.size() < 4) q0.push_back(din);
                else mo0 = 1;
            end
            // instance 1
            pp = out_ready && q1.size() != 0;
            if (pp) void'(q1.pop_front());
            if (in_valid) begin
                if (sk1 > 0) sk1--;
                else if (q1.size() < 10) q1.push_back(din);
                else mo1 = 1;
            end
        end
    end

    // Popping before the full test above is what lets push & pop coexist when full.
    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("u0.out_valid", int'(ov0), int'(q0.size() != 0));
            chk("u0.dout",      int'(do0), (q0.size() != 0) ? int'(q0[0]) : 0);
            chk("u0.count",     int'(cn0), q0.size());
            chk("u0.full",      int'(fl0), int'(q0.size() == 4));
            chk("u0.overflow",  int'(of0), int'(mo0));
            chk("u1.out_valid", int'(ov1), int'(q1.size() != 0));
            chk("u1.dout",      int'(do1), (q1.size() != 0) ? int'(q1[0]) : 0);
            chk("u1.count",     int'(cn1), q1.size());
            chk("u1.full",      int'(fl1), int'(q1.size() == 10));
            chk("u1.overflow",  int'(of1), int'(mo1));
        end
    end

    // Present inputs for one cycle; returns after the following falling edge.
    task automatic cyc(input bit iv, input logic [7:0] d, input bit rdy, input bit clr);
        in_valid = iv; din = d; out_ready = rdy; clear = clr;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
    endtask

    int seq[$];
    int peak;

    initial begin
        repeat (2) @(negedge clk);
        // reset state
        chk("rst.out_valid", int'(ov0), 0);
        chk("rst.dout",      int'(do0), 0);
        chk("rst.full",      int'(fl0), 0);
        chk("rst.count",     int'(cn1), 0);
        rstn = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;

        // T1: SKIP=2 instance, push 1..4 with out_ready=1 -> sees 3,4, peak count 1
        peak = 0;
        for (int i = 1; i <= 7; i++) begin
            if (ov1) seq.push_back(int'(do1));
            if (int'(cn1) > peak) peak = int'(cn1);
            cyc(i <= 4, 8'(i), 1'b1, 1'b0);
        end
        chk("t1.nwords", seq.size(), 2);
        if (seq.size() == 2) begin
            chk("t1.first",  seq[0], 3);
            chk("t1.second", seq[1], 4);
        end
        chk("t1.peak", peak, 1);
        chk("t1.ovf",  int'(of1), 0);

        // T4 + T2: empty SKIP=0 FIFO, push 5 words, no ready
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        chk("t4.dout_cycN", int'(do0), 0);
        cyc(1'b1, 8'hA1, 1'b0, 1'b0);
        chk("t4.valid_N1", int'(ov0), 1);
        chk("t4.dout_N1",  int'(do0), 'hA1);
        for (int i = 2; i <= 5; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        chk("t2.count", int'(cn0), 4);
        chk("t2.full",  int'(fl0), 1);
        chk("t2.ovf",   int'(of0), 1);
        for (int i = 1; i <= 4; i++) begin
            chk("t2.drain", int'(do0), 'hA0 + i);
            cyc(1'b0, 8'd0, 1'b1, 1'b0);
        end
        chk("t2.empty", int'(ov0), 0);
        chk("t2.ovf_sticky", int'(of0), 1);

        // T3: refill after clear, then push & pop for 8 cycles while full
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("t3.head", int'(do0), 'h10 + i);
            cyc(1'b1, 8'h14 + 8'(i), 1'b1, 1'b0);
            chk("t3.count", int'(cn0), 4);
        end
        chk("t3.ovf", int'(of0), 0);

        // T5: count=3 with overflow set, then clear
        cyc(1'b1, 8'h55, 1'b0, 1'b0);         // full -> overflow
        cyc(1'b0, 8'd0, 1'b1, 1'b0);          // pop -> count 3
        chk("t5.pre_count", int'(cn0), 3);
        chk("t5.pre_ovf",   int'(of0), 1);
        cyc(1'b1, 8'h66, 1'b1, 1'b1);         // clear wins over in_valid/out_ready
        chk("t5.count", int'(cn0), 0);
        chk("t5.valid", int'(ov0), 0);
        chk("t5.ovf",   int'(of0), 0);
        cyc(1'b1, 8'h01, 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 1'b0, 1'b0);
        chk("t5.skip_again", int'(cn1), 0);
        cyc(1'b1, 8'h03, 1'b0, 1'b0);
        chk("t5.after_skip", int'(cn1), 1);

        // T6: asynchronous reset between edges with count=2 in u1-free u0
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        cyc(1'b1, 8'h77, 1'b0, 1'b0);
        cyc(1'b1, 8'h78, 1'b0, 1'b0);
        chk("t6.pre_count", int'(cn0), 2);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        chk("t6.valid", int'(ov0), 0);
        chk("t6.dout",  int'(do0), 0);
        chk("t6.count", int'(cn0), 0);
        chk("t6.full",  int'(fl0), 0);
        chk("t6.ovf",   int'(of0), 0);
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);

        // Randomised traffic with occasional clears, checked by the model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 60), 8'($urandom),
                ($urandom_range(0, 99) < 45), ($urandom_range(0, 199) == 0));
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
